// File: rtl/act_quant_pipe.sv
// act_quant_pipe: two-stage activation and requantization pipeline.
// Stage 1 applies the activation; stage 2 rounds, shifts, saturates and clamps.
module act_quant_pipe #(
  parameter int DWIDTH  = 32,
  parameter int OWIDTH  = 8,
  parameter int LANES   = 4,
  parameter int SHIFT_W = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              Mode,
  input  logic [SHIFT_W-1:0]      LeakShift,
  input  logic [SHIFT_W-1:0]      OutShift,
  input  logic [OWIDTH-2:0]       ClampMax,
  input  logic                    InValid,
  output logic                    InReady,
  input  logic [LANES*DWIDTH-1:0] InData,
  output logic                    OutValid,
  input  logic                    OutReady,
  output logic [LANES*OWIDTH-1:0] OutData,
  output logic [15:0]             SatCount
);
  localparam int CW = $clog2(LANES + 1);
  localparam logic signed [DWIDTH:0] ONE = (DWIDTH+1)'(1);
  localparam logic signed [OWIDTH-1:0] MAXV =
    {1'b0, {(OWIDTH-1){1'b1}}};
  localparam logic signed [OWIDTH-1:0] MINV =
    {1'b1, {(OWIDTH-1){1'b0}}};

  logic                    v1;
  logic [LANES*DWIDTH-1:0] a1;
  logic [SHIFT_W-1:0]      os1;
  logic [OWIDTH-2:0]       cm1;
  logic                    cl1;

  logic                    adv1;
  logic                    adv2;
  logic                    acc;
  logic [LANES*DWIDTH-1:0] act;
  logic [LANES*OWIDTH-1:0] q;
  logic [LANES-1:0]        sat;
  logic [SHIFT_W-1:0]      sh;
  logic [CW-1:0]           nsat;
  logic [16:0]             cnt_sum;

  assign adv2    = !OutValid || OutReady;
  assign adv1    = !v1 || adv2;
  assign InReady = !rst && adv1;
  assign acc     = InValid && InReady;

  // Shifts past the sign bit add nothing; cap at DWIDTH-1.
  always_comb begin
    sh = os1;
    if (32'(os1) > 32'(DWIDTH - 1)) sh = SHIFT_W'(DWIDTH - 1);
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic signed [DWIDTH-1:0] x;
    logic signed [DWIDTH-1:0] a;
    logic signed [DWIDTH-1:0] y;
    logic signed [DWIDTH:0]   ext;
    logic signed [DWIDTH:0]   rnd;
    logic signed [DWIDTH:0]   r;
    logic signed [OWIDTH-1:0] qs;
    logic                     hi_ones;
    logic                     hi_zeros;

    assign x = InData[i*DWIDTH +: DWIDTH];

    always_comb begin
      a = x;
      unique case (Mode)
        2'd0:       a = x;
        2'd2:       a = x[DWIDTH-1] ? (x >>> LeakShift) : x;
        2'd1, 2'd3: a = x[DWIDTH-1] ? '0 : x;
      endcase
    end

    assign act[i*DWIDTH +: DWIDTH] = a;

    // One extra bit keeps the rounding add from overflowing.
    assign y   = a1[i*DWIDTH +: DWIDTH];
    assign ext = {y[DWIDTH-1], y};
    assign rnd = (sh == '0) ? '0 : (ONE << (sh - SHIFT_W'(1)));
    assign r   = (ext + rnd) >>> sh;

    assign hi_ones  = &r[DWIDTH:OWIDTH-1];
    assign hi_zeros = ~|r[DWIDTH:OWIDTH-1];
    assign sat[i]   = !(hi_ones || hi_zeros);

    always_comb begin
      qs = r[OWIDTH-1:0];
      if (sat[i]) qs = r[DWIDTH] ? MINV : MAXV;
      if (cl1 && (qs > $signed({1'b0, cm1}))) qs = {1'b0, cm1};
    end

    assign q[i*OWIDTH +: OWIDTH] = qs;
  end

  always_comb begin
    nsat = '0;
    for (int i = 0; i < LANES; i++) nsat = nsat + CW'(sat[i]);
  end

  assign cnt_sum = {1'b0, SatCount} + 17'(nsat);

  always_ff @(posedge clk) begin
    if (rst) begin
      v1       <= 1'b0;
      a1       <= '0;
      os1      <= '0;
      cm1      <= '0;
      cl1      <= 1'b0;
      OutValid <= 1'b0;
      OutData  <= '0;
      SatCount <= '0;
    end else begin
      if (adv1) begin
        v1 <= acc;
        if (acc) begin
          a1  <= act;
          os1 <= OutShift;
          cm1 <= ClampMax;
          cl1 <= (Mode == 2'd3);
        end
      end
      if (adv2) begin
        OutValid <= v1;
        if (v1) begin
          OutData  <= q;
          SatCount <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
        end
      end
    end
  end
endmodule

// File: tb/tb_act_quant_pipe.sv
// tb_act_quant_pipe: directed vectors for act_quant_pipe.
// Covers reset, each activation mode, rounding, saturation, backpressure, mid-stream reset.
module tb_act_quant_pipe;
  localparam int DW = 32;
  localparam int OW = 8;
  localparam int L  = 4;
  localparam int SW = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic [1:0]      Mode;
  logic [SW-1:0]   LeakShift;
  logic [SW-1:0]   OutShift;
  logic [OW-2:0]   ClampMax;
  logic            InValid;
  logic            InReady;
  logic [L*DW-1:0] InData;
  logic            OutValid;
  logic            OutReady;
  logic [L*OW-1:0] OutData;
  logic [15:0]     SatCount;

  int n_chk  = 0;
  int n_fail = 0;
  int exp_sat = 0;

  act_quant_pipe #(
    .DWIDTH(DW), .OWIDTH(OW), .LANES(L), .SHIFT_W(SW)
  ) dut (
    .clk(clk), .rst(rst), .Mode(Mode),
    .LeakShift(LeakShift), .OutShift(OutShift),
    .ClampMax(ClampMax), .InValid(InValid),
    .InReady(InReady), .InData(InData),
    .OutValid(OutValid), .OutReady(OutReady),
    .OutData(OutData), .SatCount(SatCount)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [L*DW-1:0] pin(int l0, int l1, int l2, int l3);
    return {32'(l3), 32'(l2), 32'(l1), 32'(l0)};
  endfunction

  function automatic logic [L*OW-1:0] pout(int l0, int l1, int l2, int l3);
    return {8'(l3), 8'(l2), 8'(l1), 8'(l0)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input string tag, input logic [1:0] m,
                      input int ls, input int os, input int cm,
                      input logic [L*DW-1:0] d,
                      input logic [L*OW-1:0] eq, input int sat_add);
    Mode      = m;
    LeakShift = SW'(ls);
    OutShift  = SW'(os);
    ClampMax  = (OW-1)'(cm);
    InData    = d;
    InValid   = 1'b1;
    OutReady  = 1'b1;
    #1 check({tag, "/rdy"}, InReady, 1);
    tick();
    InValid   = 1'b0;
    Mode      = ~m;
    LeakShift = '0;
    OutShift  = SW'(7);
    ClampMax  = '0;
    InData    = '1;
    #1 check({tag, "/lat1"}, OutValid, 0);
    tick();
    exp_sat += sat_add;
    #1;
    check({tag, "/valid"}, OutValid, 1);
    check({tag, "/data"}, OutData, eq);
    check({tag, "/sat"}, SatCount, exp_sat);
    tick();
    #1 check({tag, "/drain"}, OutValid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [L*OW-1:0] expq[$];
    bit pr[8] = '{1, 0, 0, 0, 1, 1, 0, 1};
    int sent = 0;
    int got  = 0;
    int occ  = 0;

    rst = 1'b1;
    Mode = 2'd0;
    LeakShift = '0;
    OutShift = '0;
    ClampMax = '0;
    InValid = 1'b1;
    InData = pin(1, 2, 3, 4);
    OutReady = 1'b1;
    tick();
    #1;
    check("rst/rdy", InReady, 0);
    check("rst/valid", OutValid, 0);
    check("rst/data", OutData, 0);
    check("rst/sat", SatCount, 0);
    tick();
    rst = 1'b0;
    InValid = 1'b0;
    #1;
    check("rst/rdy_after", InReady, 1);
    check("rst/valid_after", OutValid, 0);
    tick();
    #1 check("rst/no_accept", OutValid, 0);

    beat("relu", 2'd1, 0, 0, 0, pin(-5, 0, 100, 300),
         pout(0, 0, 100, 127), 1);
    beat("leaky", 2'd2, 2, 0, 0, pin(-8, -1, 7, -200),
         pout(-2, -1, 7, -50), 0);
    beat("round", 2'd0, 0, 4, 0, pin(24, 23, -24, -8),
         pout(2, 1, -1, 0), 0);
    beat("shift31", 2'd0, 0, 31, 0,
         pin(1 << 30, -(1 << 30), 32'h7FFF_FFFF, 32'h8000_0000),
         pout(1, 0, 1, -1), 0);
    beat("leak31", 2'd2, 31, 0, 0,
         pin(-1, 32'h8000_0000, 5, -100),
         pout(-1, -1, 5, -1), 0);
    beat("clamp", 2'd3, 0, 0, 6, pin(-3, 4, 9, 1000),
         pout(0, 4, 6, 6), 1);
    beat("negsat", 2'd0, 0, 0, 0, pin(-129, -128, 127, 128),
         pout(-128, -128, 127, 127), 2);

    Mode = 2'd0;
    OutShift = '0;
    LeakShift = '0;
    ClampMax = '0;
    for (int c = 0; c < 60 && got < 8; c++) begin
      OutReady = pr[c % 8];
      InValid  = (sent < 8);
      InData   = pin(sent + 1, sent + 2, -(sent + 1), 10 * sent);
      #1;
      check("bp/ready", InReady, !(occ == 2 && !OutReady));
      if (OutValid) begin
        if (expq.size() > 0) begin
          check("bp/data", OutData, expq[0]);
          if (OutReady) begin
            void'(expq.pop_front());
            got++;
            occ--;
          end
        end else begin
          check("bp/extra_beat", expq.size(), 1);
        end
      end
      if (InValid && InReady) begin
        expq.push_back(pout(sent + 1, sent + 2, -(sent + 1), 10 * sent));
        sent++;
        occ++;
      end
      tick();
    end
    InValid = 1'b0;
    OutReady = 1'b1;
    check("bp/count", got, 8);
    check("bp/left", expq.size(), 0);
    tick();

    OutReady = 1'b0;
    InValid = 1'b1;
    InData = pin(200, 1, 2, 3);
    tick();
    InData = pin(4, 5, 6, 7);
    tick();
    InData = pin(11, 12, 13, 14);
    exp_sat += 1;
    #1;
    check("rs/full_rdy", InReady, 0);
    check("rs/full_valid", OutValid, 1);
    check("rs/full_data", OutData, pout(127, 1, 2, 3));
    check("rs/full_sat", SatCount, exp_sat);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    OutReady = 1'b1;
    InData = pin(9, -9, 50, -50);
    #1;
    check("rs/valid", OutValid, 0);
    check("rs/sat", SatCount, 0);
    check("rs/data", OutData, 0);
    check("rs/rdy", InReady, 1);
    tick();
    InValid = 1'b0;
    #1 check("rs/lat1", OutValid, 0);
    tick();
    #1;
    check("rs/valid2", OutValid, 1);
    check("rs/data2", OutData, pout(9, -9, 50, -50));
    check("rs/sat2", SatCount, 0);
    tick();
    #1 check("rs/drain", OutValid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
